// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer.
// One small FIFO per output channel; in_sel picks the destination.
module demux1to4_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [15:0]        acc_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_OCC = (PW+1)'(DEPTH);

  logic [3:0] full;
  logic [3:0] push;
  logic [3:0] pop;
  logic       take;

  // Ready looks only at the addressed channel's occupancy.
  always_comb begin
    in_ready = !full[in_sel];
    take     = in_valid && in_ready;
  end

  for (genvar k = 0; k < 4; k++) begin : ch
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [PW:0]      occ;

    assign full[k]      = (occ == FULL_OCC);
    assign out_valid[k] = (occ != '0);
    assign push[k]      = take && (in_sel == 2'(k));
    assign pop[k]       = out_valid[k] && out_ready[k];
    assign out_data[k*WIDTH +: WIDTH] = mem[rp];

    // Per-channel FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
        wp  <= '0;
        rp  <= '0;
        occ <= '0;
      end else begin
        if (push[k]) begin
          mem[wp] <= in_data;
          wp      <= wp + 1'b1;
        end
        if (pop[k]) begin
          rp <= rp + 1'b1;
        end
        unique case ({push[k], pop[k]})
          2'b10:   occ <= occ + 1'b1;
          2'b01:   occ <= occ - 1'b1;
          default: occ <= occ;
        endcase
      end
    end
  end

  // Count every accepted word; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_count <= '0;
    end else if (take) begin
      acc_count <= acc_count + 16'd1;
    end
  end

endmodule
